// File: rtl/hb_pkg.sv
// Shared half-band constants and bundles for the Rx/Tx rate-change stages.
// Coefficients are common to the E1 interpolator and the D1 decimator.
package hb_pkg;

  localparam int DATA_W = 15;
  localparam int ACC_W  = 25;
  localparam int SHIFT  = 9;
  localparam int PA_W   = DATA_W + 1;
  localparam int NTAP   = 19;

  localparam int C0 = 1;
  localparam int C1 = -4;
  localparam int C2 = 13;
  localparam int C3 = -40;
  localparam int C4 = 158;
  localparam int CC = 256;

  localparam int OUT_MAX = 16383;
  localparam int OUT_MIN = -16384;

  typedef logic signed [DATA_W-1:0] smp_t;
  typedef logic signed [PA_W-1:0]   pre_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef struct packed {
    pre_t a0;
    pre_t a1;
    pre_t a2;
    pre_t a3;
    pre_t a4;
    smp_t xc;
  } s1_t;

  typedef struct packed {
    acc_t pa;
    acc_t pb;
  } s2_t;

  function automatic pre_t padd(
    input smp_t a,
    input smp_t b
  );
    return PA_W'(a) + PA_W'(b);
  endfunction

endpackage

// File: rtl/hb_round_sat.sv
// Round-half-up, arithmetic shift and clip of a wide accumulator.
// Purely combinational so it can close any filter stage.
module hb_round_sat #(
  parameter int ACC_W  = 25,
  parameter int DATA_W = 15,
  parameter int SHIFT  = 9,
  parameter int MAXV   = 16383,
  parameter int MINV   = -16384
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_sat
);

  localparam logic signed [ACC_W-1:0] RND =
    ACC_W'(1 << (SHIFT - 1));
  localparam logic signed [ACC_W-1:0] HI =
    ACC_W'(MAXV);
  localparam logic signed [ACC_W-1:0] LO =
    ACC_W'(MINV);

  logic signed [ACC_W-1:0] w_rnd;
  logic signed [ACC_W-1:0] w_shr;

  assign w_rnd = i_acc + RND;
  assign w_shr = w_rnd >>> SHIFT;

  always_comb begin
    o_sat  = 1'b0;
    o_data = w_shr[DATA_W-1:0];
    unique case (1'b1)
      (w_shr > HI): begin
        o_sat  = 1'b1;
        o_data = DATA_W'(MAXV);
      end
      (w_shr < LO): begin
        o_sat  = 1'b1;
        o_data = DATA_W'(MINV);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/d1_hb_dec.sv
// Rx 2:1 decimating half-band FIR, 19 taps, three-stage pipeline.
// A phase-1 acceptance launches one output three edges later.
module d1_hb_dec
  import hb_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sync_clr,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_D1,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_D1,
  output logic                     out_sat
);

  smp_t r_x [NTAP];
  logic r_ph;
  logic r_v0;
  logic r_v1;
  logic r_v2;
  s1_t  r_s1;
  s2_t  r_s2;

  acc_t w_sum;
  smp_t w_y;
  logic w_sat;

  assign w_sum = r_s2.pa + r_s2.pb;

  hb_round_sat #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .SHIFT  (SHIFT),
    .MAXV   (OUT_MAX),
    .MINV   (OUT_MIN)
  ) u_rs (
    .i_acc  (w_sum),
    .o_data (w_y),
    .o_sat  (w_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAP; k++) begin
        r_x[k] <= '0;
      end
      r_ph      <= 1'b0;
      r_v0      <= 1'b0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_s1      <= '0;
      r_s2      <= '0;
      out_valid <= 1'b0;
      out_D1    <= '0;
      out_sat   <= 1'b0;
    end else if (sync_clr) begin
      for (int k = 0; k < NTAP; k++) begin
        r_x[k] <= '0;
      end
      r_ph      <= 1'b0;
      r_v0      <= 1'b0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid) begin
        r_x[0] <= in_D1;
        for (int k = 1; k < NTAP; k++) begin
          r_x[k] <= r_x[k-1];
        end
        r_ph <= ~r_ph;
      end
      r_v0      <= in_valid & r_ph;
      r_v1      <= r_v0;
      r_v2      <= r_v1;
      out_valid <= r_v2;
      // window is stable here even if a new sample shifts in
      if (r_v0) begin
        r_s1 <= '{
          a0: padd(r_x[0], r_x[18]),
          a1: padd(r_x[2], r_x[16]),
          a2: padd(r_x[4], r_x[14]),
          a3: padd(r_x[6], r_x[12]),
          a4: padd(r_x[8], r_x[10]),
          xc: r_x[9]
        };
      end
      if (r_v1) begin
        r_s2.pa <= ACC_W'(C0 * r_s1.a0
                        + C1 * r_s1.a1
                        + C2 * r_s1.a2);
        r_s2.pb <= ACC_W'(C3 * r_s1.a3
                        + C4 * r_s1.a4
                        + CC * r_s1.xc);
      end
      if (r_v2) begin
        out_D1  <= w_y;
        out_sat <= w_sat;
      end
    end
  end

endmodule

// File: tb/tb_d1_hb_dec.sv
// Scoreboard bench for d1_hb_dec: driver pushes model results,
// a negedge monitor pops and compares on every out_valid.
module tb_d1_hb_dec;

  logic              clk;
  logic              rst_n;
  logic              sync_clr;
  logic              in_valid;
  logic signed [14:0] in_D1;
  logic              out_valid;
  logic signed [14:0] out_D1;
  logic              out_sat;

  d1_hb_dec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync_clr  (sync_clr),
    .in_valid  (in_valid),
    .in_D1     (in_D1),
    .out_valid (out_valid),
    .out_D1    (out_D1),
    .out_sat   (out_sat)
  );

  typedef struct {
    int val;
    bit sat;
    int due;
    bit he;
    int hv;
    bit hs;
  } ent_t;

  ent_t q[$];
  ent_t m_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mx [19];
  bit   mph;
  int   h [19] = '{1, 0, -4, 0, 13, 0, -40, 0, 158, 256,
                   158, 0, -40, 0, 13, 0, -4, 0, 1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic model_clr();
    for (int k = 0; k < 19; k++) mx[k] = 0;
    mph = 1'b0;
  endtask

  // floor((y+256)/512) done with truncating division plus correction
  function automatic int rnd_floor(input int y);
    int v;
    int r;
    v = y + 256;
    r = v / 512;
    if (v < 0 && (v % 512) != 0) r = r - 1;
    return r;
  endfunction

  task automatic feed(input bit v, input int d, input bit clr,
                      input bit he = 0, input int hv = 0,
                      input bit hs = 0);
    ent_t e;
    int   y;
    @(negedge clk);
    sync_clr = clr;
    in_valid = v;
    in_D1    = 15'(d);
    if (clr) begin
      model_clr();
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    end else if (v) begin
      for (int k = 18; k > 0; k--) mx[k] = mx[k-1];
      mx[0] = d;
      if (mph) begin
        y = 0;
        for (int k = 0; k < 19; k++) y += h[k] * mx[k];
        e.val = rnd_floor(y);
        e.sat = 1'b0;
        if (e.val > 16383) begin
          e.val = 16383;
          e.sat = 1'b1;
        end
        if (e.val < -16384) begin
          e.val = -16384;
          e.sat = 1'b1;
        end
        e.due = cyc + 4;
        e.he  = he;
        e.hv  = hv;
        e.hs  = hs;
        q.push_back(e);
      end
      mph = ~mph;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) feed(1'b0, 0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing out_valid: none by cycle %0d, required at %0d",
               cyc, q[0].due);
      void'(q.pop_front());
    end
    if (out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious out_valid: got 1, required 0 (cycle %0d)",
                 cyc);
      end else begin
        m_e = q.pop_front();
        chk("latency", cyc, m_e.due);
        chk("out_D1", int'(out_D1), m_e.val);
        chk("out_sat", int'(out_sat), int'(m_e.sat));
        if (m_e.he) begin
          chk("hand out_D1", int'(out_D1), m_e.hv);
          chk("hand out_sat", int'(out_sat), int'(m_e.hs));
        end
      end
    end
  end

  int h1 [12] = '{2, -8, 25, -78, 309, 309, -78, 25, -8, 2, 0, 0};
  int h0 [12] = '{0, 0, 0, 0, 500, 0, 0, 0, 0, 0, 0, 0};
  int pp [19];

  task automatic imp1();
    feed(1'b0, 0, 1'b1);
    for (int i = 0; i < 24; i++)
      feed(1'b1, (i == 1) ? 1000 : 0, 1'b0,
           i[0], (i[0]) ? h1[(i - 1) / 2] : 0, 1'b0);
    idle(5);
  endtask

  task automatic sat_run(input bit neg);
    feed(1'b0, 0, 1'b1);
    feed(1'b1, 0, 1'b0);
    for (int k = 18; k >= 0; k--)
      feed(1'b1, neg ? -pp[k] - 1 : pp[k], 1'b0,
           (k == 0), neg ? -16384 : 16383, 1'b1);
    idle(5);
  endtask

  initial begin
    rst_n    = 1'b0;
    sync_clr = 1'b0;
    in_valid = 1'b0;
    in_D1    = '0;
    model_clr();
    repeat (3) @(negedge clk);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_D1", int'(out_D1), 0);
    chk("reset out_sat", int'(out_sat), 0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 24; i++)
      feed(1'b1, (i == 0) ? 1000 : 0, 1'b0,
           i[0], (i[0]) ? h0[(i - 1) / 2] : 0, 1'b0);
    idle(5);

    imp1();

    feed(1'b0, 0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      feed(1'b1, 1000, 1'b0, (i >= 19) && i[0], 1000, 1'b0);
    end
    idle(5);

    for (int k = 0; k < 19; k++) pp[k] = 0;
    pp[0] = 16383; pp[4] = 16383; pp[8] = 16383; pp[9] = 16383;
    pp[10] = 16383; pp[14] = 16383; pp[18] = 16383;
    pp[2] = -16384; pp[6] = -16384; pp[12] = -16384; pp[16] = -16384;
    sat_run(1'b0);
    sat_run(1'b1);

    feed(1'b0, 0, 1'b1);
    for (int i = 0; i < 7; i++)
      feed(1'b1, int'($urandom_range(0, 8000)) - 4000, 1'b0);
    feed(1'b1, 1234, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sync_clr = 1'b0;
      in_valid = 1'b0;
      chk("post-clr out_valid", int'(out_valid), 0);
    end
    feed(1'b1, 300, 1'b0);
    feed(1'b1, 1000, 1'b0, 1'b1, 2, 1'b0);
    idle(5);

    feed(1'b0, 0, 1'b1);
    for (int i = 0; i < 24; i++) feed(1'b1, 1000, 1'b0);
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    sync_clr = 1'b0;
    in_valid = 1'b0;
    q.delete();
    model_clr();
    #1;
    chk("async rst out_valid", int'(out_valid), 0);
    chk("async rst out_D1", int'(out_D1), 0);
    chk("async rst out_sat", int'(out_sat), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    imp1();
    idle(6);
    chk("scoreboard drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
